// File: rtl/cla_adder_arbiter.sv
// Arbitrates NREQ requesters onto one shared combinational adder: grant, hold operands ADD_LAT cycles, return a one-hot result pulse.
// Define CLA_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module cla_adder_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic [NREQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]      resp_sum,
  output logic                  resp_cout,
  output logic                  busy
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, next_state;
  logic [GW-1:0]   last_grant, gnt, pick_idx;
  logic            pick_any;
  logic [LW-1:0]   lat_cnt;
  logic [WIDTH-1:0] op_a, op_b;
  logic            op_cin;

  // Grant search; in round-robin the smallest rotation distance from last_grant wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick_idx = '0;
    pick_any = 1'b0;
`ifdef CLA_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        pick_any = 1'b1;
        pick_idx = GW'(i);
      end
    end
`else
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (req_valid[idx]) begin
        pick_any = 1'b1;
        pick_idx = GW'(idx);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_any) next_state = EXEC;
      EXEC:    if (lat_cnt == '0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    busy       = (state != IDLE);
    if (state == IDLE && !rst && pick_any) req_ready = NREQ'(1) << pick_idx;
    if (state == RESP)                     resp_valid = NREQ'(1) << gnt;
  end

  // Datapath: operand latches only move on acceptance, so the adder inputs stay quiet otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GW'(NREQ - 1);
      gnt        <= '0;
      lat_cnt    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          gnt     <= pick_idx;
          op_a    <= req_a[int'(pick_idx)*WIDTH +: WIDTH];
          op_b    <= req_b[int'(pick_idx)*WIDTH +: WIDTH];
          op_cin  <= req_cin[pick_idx];
          lat_cnt <= LW'(ADD_LAT - 1);
        end
        EXEC: if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
              else begin
                resp_sum  <= add_sum;
                resp_cout <= add_cout;
              end
        RESP: last_grant <= gnt;
        default: ;
      endcase
    end
  end

  assign add_a   = op_a;
  assign add_b   = op_b;
  assign add_cin = op_cin;
endmodule

// File: tb/tb_cla_adder_arbiter.sv
// Random and directed checks of cla_adder_arbiter against a transaction-level reference model.
module tb_cla_adder_arbiter;
  localparam int W = 32, N = 4;

  logic clk = 0, rst, rst4;
  logic [N-1:0]   req_valid, req_cin;
  logic [N*W-1:0] req_a, req_b;

  logic [N-1:0] req_ready, resp_valid, req_ready4, resp_valid4;
  logic [W-1:0] add_a, add_b, add_sum, resp_sum, add_a4, add_b4, add_sum4, resp_sum4;
  logic add_cin, add_cout, resp_cout, busy, add_cin4, add_cout4, resp_cout4, busy4;

  always #5 clk = ~clk;

  assign {add_cout, add_sum}   = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};
  assign {add_cout4, add_sum4} = {1'b0, add_a4} + {1'b0, add_b4} + {32'b0, add_cin4};

  cla_adder_arbiter #(.WIDTH(W), .NREQ(N), .ADD_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .req_ready(req_ready), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout), .resp_valid(resp_valid),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .busy(busy));

  cla_adder_arbiter #(.WIDTH(W), .NREQ(N), .ADD_LAT(4)) dut4 (
    .clk(clk), .rst(rst4), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .req_ready(req_ready4), .add_a(add_a4), .add_b(add_b4),
    .add_cin(add_cin4), .add_sum(add_sum4), .add_cout(add_cout4), .resp_valid(resp_valid4),
    .resp_sum(resp_sum4), .resp_cout(resp_cout4), .busy(busy4));

  int errors = 0, checks = 0, cyc = 0;
  // Reference model: cycles left on the in-flight op (0 = free) and what it must return.
  int rem = 0, mg = 0, mlast = N - 1;
  logic [W:0]   mres;
  logic [W-1:0] ma = '0, mb = '0;
  logic         mc = 1'b0;
  int g_cyc[$], g_idx[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef CLA_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  task automatic step();
    int p;
    logic acc;
    @(negedge clk);
    p   = pick(req_valid, mlast);
    acc = !rst && rem == 0 && p >= 0;
    chk("req_ready", req_ready, acc ? 4'(1 << p) : 4'b0);
    chk("busy", busy, rem > 0);
    chk("resp_valid", resp_valid, rem == 1 ? 4'(1 << mg) : 4'b0);
    if (rem == 1) begin
      chk("resp_sum", resp_sum, mres[W-1:0]);
      chk("resp_cout", resp_cout, mres[W]);
    end
    chk("add_a", add_a, ma);
    chk("add_b", add_b, mb);
    chk("add_cin", add_cin, mc);
    for (int i = 0; i < N; i++)
      if (req_ready[i]) begin g_cyc.push_back(cyc); g_idx.push_back(i); break; end
    @(posedge clk);
    if (rst) begin
      rem = 0; mlast = N - 1; ma = '0; mb = '0; mc = 1'b0;
    end else if (rem > 0) begin
      if (rem == 1) mlast = mg;
      rem--;
    end else if (acc) begin
      mg   = p;
      ma   = req_a[p*W +: W];
      mb   = req_b[p*W +: W];
      mc   = req_cin[p];
      mres = {1'b0, ma} + {1'b0, mb} + {32'b0, mc};
      rem  = 2;
    end
    cyc++;
    #1;
  endtask

  task automatic single(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] es, input logic ec, input string tag);
    req_valid = 4'(1 << i);
    req_a[i*W +: W] = a; req_b[i*W +: W] = b; req_cin[i] = c;
    step();
    req_valid = '0;
    step();
    chk({tag, "_valid"}, resp_valid, 4'(1 << i));
    chk({tag, "_sum"}, resp_sum, es);
    chk({tag, "_cout"}, resp_cout, ec);
    step();
  endtask

  initial begin
    rst = 1; rst4 = 1;
    req_valid = '0; req_cin = '0; req_a = '0; req_b = '0;
    step();
    req_valid = '1;          // reset beats a simultaneous request
    step();
    chk("rst_ready", req_ready, 4'b0);
    chk("rst_sum", resp_sum, 0);
    chk("rst_cout", resp_cout, 0);
    chk("rst_busy", busy, 0);
    req_valid = '0; rst = 0;
    step();

    single(1, 32'h5, 32'h3, 1'b0, 32'h8, 1'b0, "single");
    single(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, "wrap");
    single(2, 32'h7FFF_FFFF, 32'h0, 1'b1, 32'h8000_0000, 1'b0, "cin");

    // Arbitration order with several requesters held high.
    rst = 1; step(); rst = 0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 32'h100 * (i + 1); req_b[i*W +: W] = i; req_cin[i] = i[0];
    end
    g_cyc.delete(); g_idx.delete();
`ifdef CLA_ARB_FIXED_PRIO_EN
    req_valid = 4'b1001;
    repeat (9) step();
    req_valid = 4'b1000;
    repeat (3) step();
    chk("fp_grants", g_idx.size(), 4);
    for (int k = 0; k < 3; k++) chk($sformatf("fp_grant%0d", k), g_idx[k], 0);
    chk("fp_grant3", g_idx[3], 3);
`else
    req_valid = 4'b1111;
    repeat (18) step();
    chk("rr_grants", g_idx.size(), 6);
    for (int k = 0; k < 6; k++) chk($sformatf("rr_grant%0d", k), g_idx[k], k % 4);
    for (int k = 1; k < 6; k++) chk($sformatf("rr_gap%0d", k), g_cyc[k] - g_cyc[k-1], 3);
`endif
    req_valid = '0;
    step(); step();

    // Requester 3 arrives while 0 is in flight; it must wait for IDLE.
    rst = 1; step(); rst = 0;
    g_cyc.delete(); g_idx.delete();
    req_valid = 4'b0001;
    step();
    req_valid = 4'b1000;
    repeat (4) step();
    req_valid = '0;
    chk("blk_grants", g_idx.size(), 2);
    chk("blk_first", g_idx[0], 0);
    chk("blk_second", g_idx[1], 3);
    chk("blk_gap", g_cyc[1] - g_cyc[0], 3);
    step(); step();

    for (int n = 0; n < 400; n++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        req_a[i*W +: W] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        req_b[i*W +: W] = $urandom;
        req_cin[i]      = 1'($urandom);
      end
      rst = ($urandom_range(0, 60) == 0);
      step();
    end

    // ADD_LAT=4 instance: latency, then an operation dropped by reset.
    rst = 1; rst4 = 0; req_valid = 4'b0001;
    req_a[0 +: W] = 32'd10; req_b[0 +: W] = 32'd20; req_cin = '0;
    @(negedge clk);
    chk("l4_ready", req_ready4, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("l4_busy%0d", k), busy4, 1);
      chk($sformatf("l4_resp%0d", k), resp_valid4, k == 5 ? 4'b0001 : 4'b0);
      if (k == 5) chk("l4_sum", resp_sum4, 32'd30);
      @(posedge clk); #1;
    end
    req_valid = 4'b0010; req_a[W +: W] = 32'd1; req_b[W +: W] = 32'd1;
    @(negedge clk);
    chk("l4_ready1", req_ready4, 4'b0010);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1 rst4 = 1;
    @(posedge clk); #1 rst4 = 0;
    @(negedge clk);
    chk("l4_rst_busy", busy4, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("l4_drop%0d", k), resp_valid4, 4'b0);
    end
    @(posedge clk); #1 req_valid = 4'b0101;
    @(negedge clk);
    chk("l4_after_rst", req_ready4, 4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
